// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: round-robin choice between the ALU (A) and load unit (B),
// a one-entry write stage in front of the register file, and a pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int XLEN    = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            hold,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            rf_we,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wdata,
  output logic [31:0]     busy,
  output logic            last_grant
);

  // Handshake: a request transfers on a rising edge where x_valid && x_ready.
  // Ready is only raised for a valid requester, so ready alone means "accepted
  // this cycle"; requesters hold valid/rd/data stable until they see ready.
  logic            r_ptr;
  logic            r_last_grant;
  logic            r_stage_valid;
  logic [4:0]      r_stage_rd;
  logic [XLEN-1:0] r_stage_data;
  logic [31:0]     r_busy;

  logic            w_contend;
  logic            w_a_xfer;
  logic            w_b_xfer;
  logic            w_xfer;
  logic            w_rf_we;
  logic [31:0]     w_set;
  logic [31:0]     w_clr;

  always_comb begin
    a_ready = !rst && !hold && a_valid && (!b_valid || !r_ptr);
    b_ready = !rst && !hold && b_valid && (!a_valid ||  r_ptr);
  end

  assign w_contend = a_valid && b_valid;
  assign w_a_xfer  = a_valid && a_ready;
  assign w_b_xfer  = b_valid && b_ready;
  assign w_xfer    = w_a_xfer || w_b_xfer;

  // Pointer names the loser of the last contended transfer; solo transfers leave it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= RR_INIT;
      r_last_grant <= RR_INIT;
    end else if (w_xfer) begin
      r_last_grant <= w_b_xfer;
      if (w_contend) r_ptr <= w_a_xfer;
    end
  end

  // The stage drains every non-hold cycle; hold freezes valid, rd and data alike.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage_valid <= 1'b0;
      r_stage_rd    <= '0;
      r_stage_data  <= '0;
    end else if (!hold) begin
      r_stage_valid <= w_xfer;
      if (w_xfer) begin
        r_stage_rd   <= w_b_xfer ? b_rd   : a_rd;
        r_stage_data <= w_b_xfer ? b_data : a_data;
      end
    end
  end

  assign w_rf_we = r_stage_valid && !hold && (r_stage_rd != 5'd0);

  // Set wins over clear so a re-issued destination stays pending.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid) w_set = 32'd1 << issue_rd;
    if (w_rf_we)     w_clr = 32'd1 << r_stage_rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= ((r_busy & ~w_clr) | w_set) & ~32'd1;
  end

  assign rf_we      = w_rf_we;
  assign rf_rd      = r_stage_rd;
  assign rf_wdata   = r_stage_data;
  assign busy       = r_busy;
  assign last_grant = r_last_grant;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: table of per-cycle vectors with expected grants,
// a write scoreboard queue, and hand sequences for busy tracking and reset mid-stall.
module tb_regfile_wb_arbiter;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            a_valid;
  logic [4:0]      a_rd;
  logic [XLEN-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [4:0]      b_rd;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            hold;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy;
  logic            last_grant;

  regfile_wb_arbiter #(.XLEN(XLEN), .RR_INIT(1'b0)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .hold(hold), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .busy(busy), .last_grant(last_grant)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            av;
    logic [4:0]      ard;
    logic [XLEN-1:0] ad;
    logic            bv;
    logic [4:0]      brd;
    logic [XLEN-1:0] bd;
    logic            hld;
    logic            iv;
    logic [4:0]      ird;
    logic            exp_ar;
    logic            exp_br;
    logic            exp_lg;
  } vec_t;

  // Scoreboard: {rd, data} of accepted requests that must reach the register file.
  logic [4+XLEN:0] exp_q[$];
  int n_cmp;
  int n_fail;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [XLEN-1:0] ad,
                              input logic bv, input logic [4:0] brd, input logic [XLEN-1:0] bd,
                              input logic hld, input logic ear, input logic ebr, input logic elg);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.bv = bv; v.brd = brd; v.bd = bd;
    v.hld = hld; v.iv = 1'b0; v.ird = 5'd0;
    v.exp_ar = ear; v.exp_br = ebr; v.exp_lg = elg;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Entered just after a rising edge; returns just after the next one.
  task automatic step(input vec_t v, input string tag);
    logic            exp_we;
    logic [4+XLEN:0] e;
    a_valid = v.av; a_rd = v.ard; a_data = v.ad;
    b_valid = v.bv; b_rd = v.brd; b_data = v.bd;
    hold = v.hld; issue_valid = v.iv; issue_rd = v.ird;
    @(negedge clk);
    chk({tag, ".a_ready"}, XLEN'(a_ready), XLEN'(v.exp_ar));
    chk({tag, ".b_ready"}, XLEN'(b_ready), XLEN'(v.exp_br));
    exp_we = (exp_q.size() > 0) && !v.hld;
    chk({tag, ".rf_we"}, XLEN'(rf_we), XLEN'(exp_we));
    if (exp_we && rf_we) begin
      e = exp_q.pop_front();
      chk({tag, ".rf_rd"},    XLEN'(rf_rd), XLEN'(e[4+XLEN:XLEN]));
      chk({tag, ".rf_wdata"}, rf_wdata,     e[XLEN-1:0]);
    end else if (exp_we) begin
      void'(exp_q.pop_front());
    end
    if (v.av && v.exp_ar && v.ard != 5'd0) exp_q.push_back({v.ard, v.ad});
    else if (v.bv && v.exp_br && v.brd != 5'd0) exp_q.push_back({v.brd, v.bd});
    @(posedge clk);
    #1;
    chk({tag, ".last_grant"}, XLEN'(last_grant), XLEN'(v.exp_lg));
  endtask

  vec_t tbl[18];
  vec_t v;
  logic [XLEN-1:0] d [8];

  initial begin
    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 8; i++) d[i] = $urandom_range(32'hFFFF_FFFF, 0);

    //            av ard    ad            bv brd    bd      hld ear ebr lg
    tbl[0]  = mk(1, 5'd5,  32'hDEADBEEF, 0, 5'd0,  0,      0,  1,  0,  0);
    tbl[1]  = mk(0, 5'd0,  0,            0, 5'd0,  0,      0,  0,  0,  0);
    tbl[2]  = mk(1, 5'd10, d[0],         1, 5'd20, d[1],   0,  1,  0,  0);
    tbl[3]  = mk(1, 5'd11, d[2],         1, 5'd20, d[1],   0,  0,  1,  1);
    tbl[4]  = mk(1, 5'd11, d[2],         1, 5'd21, d[3],   0,  1,  0,  0);
    tbl[5]  = mk(1, 5'd12, d[4],         1, 5'd21, d[3],   0,  0,  1,  1);
    tbl[6]  = mk(1, 5'd12, d[4],         0, 5'd0,  0,      0,  1,  0,  0);
    tbl[7]  = mk(0, 5'd0,  0,            1, 5'd7,  32'h12, 0,  0,  1,  1);
    tbl[8]  = mk(1, 5'd13, d[5],         1, 5'd22, d[6],   1,  0,  0,  1);
    tbl[9]  = mk(1, 5'd13, d[5],         1, 5'd22, d[6],   1,  0,  0,  1);
    tbl[10] = mk(1, 5'd13, d[5],         1, 5'd22, d[6],   1,  0,  0,  1);
    tbl[11] = mk(1, 5'd13, d[5],         1, 5'd22, d[6],   0,  1,  0,  0);
    tbl[12] = mk(0, 5'd0,  0,            1, 5'd22, d[6],   0,  0,  1,  1);
    tbl[13] = mk(1, 5'd14, d[7],         1, 5'd23, d[0],   0,  0,  1,  1);
    tbl[14] = mk(1, 5'd14, d[7],         0, 5'd0,  0,      0,  1,  0,  0);
    tbl[15] = mk(1, 5'd0,  d[1],         1, 5'd24, d[2],   0,  1,  0,  0);
    tbl[16] = mk(0, 5'd0,  0,            1, 5'd24, d[2],   0,  0,  1,  1);
    tbl[17] = mk(0, 5'd0,  0,            0, 5'd0,  0,      0,  0,  0,  1);

    // Reset values hold even with requests present.
    rst = 1'b1;
    a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h55;
    b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h66;
    hold = 1'b0; issue_valid = 1'b1; issue_rd = 5'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.a_ready",    XLEN'(a_ready),    0);
    chk("rst.b_ready",    XLEN'(b_ready),    0);
    chk("rst.rf_we",      XLEN'(rf_we),      0);
    chk("rst.rf_rd",      XLEN'(rf_rd),      0);
    chk("rst.rf_wdata",   rf_wdata,          0);
    chk("rst.busy",       busy,              0);
    chk("rst.last_grant", XLEN'(last_grant), 0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) step(tbl[i], $sformatf("vec%0d", i));
    chk("vec.busy", busy, 0);

    // Scoreboard: set, simultaneous set+clear, then clear.
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    v.iv = 1'b1; v.ird = 5'd9;
    step(v, "sb_issue");
    chk("sb.busy9_set", XLEN'(busy[9]), 1);
    step(mk(1, 5'd9, 32'hA5A5, 0, 0, 0, 0, 1, 0, 0), "sb_wb1");
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.iv = 1'b1; v.ird = 5'd9;
    step(v, "sb_setclr");
    chk("sb.busy9_kept", XLEN'(busy[9]), 1);
    step(mk(1, 5'd9, 32'h5A5A, 0, 0, 0, 0, 1, 0, 0), "sb_wb2");
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.iv = 1'b1; v.ird = 5'd0;
    step(v, "sb_clr");
    chk("sb.busy_all_clear", busy, 0);

    // Reset mid-stall: the staged entry must never be written.
    v = mk(1, 5'd17, 32'hCAFE, 0, 0, 0, 0, 1, 0, 0);
    v.iv = 1'b1; v.ird = 5'd17;
    step(v, "ms_accept");
    chk("ms.busy17", XLEN'(busy[17]), 1);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0), "ms_hold");
    #2 rst = 1'b1;
    #1;
    chk("ms.busy_async",  busy,           0);
    chk("ms.rf_we_async", XLEN'(rf_we),   0);
    chk("ms.rf_rd_async", XLEN'(rf_rd),   0);
    @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
    // First edge after release accepts; hold low again, nothing pending.
    step(mk(0, 0, 0, 1, 5'd30, 32'hBEEF, 0, 0, 1, 1), "ms_first");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ms_drain");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ms_idle");
    chk("ms.busy_after", busy, 0);
    chk("end.queue_empty", XLEN'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter XLEN, default 32: data width of write-back payloads and register-file write data.
REQ-002 Parameter RR_INIT, default 0: priority pointer value after reset (0 = requester A first, 1 = requester B first).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 a_valid  input  1  requester A (ALU) write-back request.
REQ-006 a_rd  input  5  requester A destination register.
REQ-007 a_data  input  XLEN  requester A write data.
REQ-008 a_ready  output  1  requester A request accepted this cycle.
REQ-009 b_valid, b_rd, b_data, b_ready  as REQ-005..008  requester B (load unit).
REQ-010 hold  input  1  freeze write stage; no acceptance, no register-file write.
REQ-011 issue_valid  input  1  an instruction with destination issue_rd is dispatched.
REQ-012 issue_rd  input  5  destination of the dispatched instruction.
REQ-013 rf_we  output  1  register-file write enable.
REQ-014 rf_rd  output  5  register-file write address.
REQ-015 rf_wdata  output  XLEN  register-file write data.
REQ-016 busy  output  32  scoreboard; bit n = write to xn outstanding.
REQ-017 last_grant  output  1  0 = A won most recent acceptance, 1 = B.

Function
REQ-018 A transfer SHALL occur on a rising edge where x_valid and x_ready are both high; at most one transfer SHALL occur per cycle.
REQ-019 a_ready/b_ready SHALL be combinational: low while hold=1; otherwise, with a single valid requester, that requester's ready is high; with both valid, only the prioritised requester's ready is high.
REQ-020 The priority pointer SHALL point to the requester that did not win the most recent contended transfer; uncontended transfers SHALL NOT change the pointer.
REQ-021 An accepted request SHALL load a one-entry write stage (valid bit, rd, data) at the acceptance edge.
REQ-022 rf_we SHALL equal stage_valid AND NOT hold AND (stage rd != 0); latency from acceptance edge to rf_we high SHALL be one cycle when hold=0.
REQ-023 While hold=1 the stage contents SHALL remain unchanged and rf_rd/rf_wdata SHALL remain stable; the entry SHALL write in the first cycle hold=0.
REQ-024 With hold=0 the stage SHALL drain every cycle; when no transfer occurs, stage_valid SHALL clear.
REQ-025 Requests with rd=0 SHALL be accepted normally but SHALL never assert rf_we.
REQ-026 Requesters SHALL hold valid, rd and data stable until ready; the block SHALL never drop or duplicate an accepted request.
REQ-027 busy[issue_rd] SHALL set on the edge after issue_valid=1 when issue_rd != 0.
REQ-028 busy[rf_rd] SHALL clear on the edge at the end of the cycle in which rf_we=1.
REQ-029 Simultaneous set and clear of the same register SHALL leave the bit set.
REQ-030 busy[0] SHALL be constant 0.
REQ-031 Same-rd requests from A and B SHALL be serialised purely by arbitration; no merging.

Reset
REQ-032 While rst=1: a_ready=b_ready=0, rf_we=0, rf_rd=0, rf_wdata=0, busy=0, stage empty, pointer=RR_INIT, last_grant=RR_INIT.
REQ-033 Reset asserted mid-operation SHALL discard the staged entry without a write and clear all busy bits immediately.
REQ-034 The first acceptance SHALL be possible on the first rising edge after rst deasserts.

Verification
REQ-035 Single A: a_valid=1, a_rd=5, a_data=0xDEADBEEF at edge N -> a_ready=1 during N; rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF during N+1.
REQ-036 Contention: A and B valid for 4 cycles, RR_INIT=0 -> grants A,B,A,B; last_grant 0,1,0,1; four writes in consecutive cycles.
REQ-037 Hold: accept B rd=7 data=0x12, hold=1 for 3 cycles -> rf_we=0 and both ready low for 3 cycles; rf_we=1, rd=7, data=0x12 in the first hold=0 cycle.
REQ-038 x0: A rd=0 accepted -> a_ready=1, no rf_we pulse; busy unchanged.
REQ-039 Scoreboard: issue rd=9 -> busy[9]=1 next cycle; write-back rd=9 with issue rd=9 in the same cycle -> busy[9] remains 1.
REQ-040 Reset mid-stall: stage full, hold=1, rst pulsed -> busy=0, rf_we=0 after release; the staged entry is never written.
